stack_pop_unit: RTL and testbench
=================================

// Module: stack_pop_unit
// PURPOSE
//  Executes the POP instruction of the stack processor: moves pop_cnt entries from the top of
//  the stack RAM into data memory at consecutive addresses. Counterpart of the push path, which
//  fills the stack. Sits between the instruction decoder (start/done) and the stack RAM read port.
//  Sits between the shared SP register (sp_dec) and the data memory write port.
// PARAMETERS
//  DW  8  data width of a stack entry / data memory word
//  AW  8  address width of stack RAM and data memory; stack depth 2**AW
//  CW  4  width of pop count field
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  reset      in   1   synchronous, active-high reset
//  start      in   1   one-cycle request from decoder; sampled only in IDLE
//  pop_cnt    in   CW  number of entries to pop; 0 = no-op
//  dst_addr   in   AW  data memory address receiving the first (topmost) popped entry
//  sp         in   AW  current SP = number of valid entries; top entry at sp-1
//  stk_ren    out  1   stack RAM read enable
//  stk_raddr  out  AW  stack RAM read address
//  stk_rdata  in   DW  stack RAM read data, valid the cycle after stk_ren
//  sp_dec     out  1   one-cycle strobe: SP register decrements by 1
//  dm_wen     out  1   data memory write enable
//  dm_waddr   out  AW  data memory write address
//  dm_wdata   out  DW  data memory write data
//  busy       out  1   high in every state except IDLE
//  done       out  1   one-cycle completion pulse
//  underflow  out  1   sticky error flag, cleared by the next accepted start or reset
// BEHAVIOUR
//  - Reset: state=IDLE; stk_ren, sp_dec, dm_wen, busy, done, underflow = 0; addr/data outs = 0.
//  - FSM states IDLE, RD, WR, FIN. Outputs are registered-state decodes, no input->output paths
//    except dm_wdata = stk_rdata in WR.
//  - IDLE: on start, latch cnt<=pop_cnt, waddr<=dst_addr, lsp<=sp, clear underflow.
//      cnt==0 -> FIN; lsp==0 -> set underflow, FIN; else -> RD. start outside IDLE ignored.
//  - RD: stk_ren=1, stk_raddr=lsp-1 -> WR.
//  - WR: dm_wen=1, dm_waddr=waddr, dm_wdata=stk_rdata, sp_dec=1; lsp--, cnt--, waddr++.
//      new cnt==0 -> FIN; else new lsp==0 -> set underflow, FIN; else -> RD.
//  - FIN: done=1 for exactly one cycle -> IDLE.
//  - Timing: start sampled at edge 0; N pops take 2N cycles; done high in cycle 2N+1.
//    cnt==0 or sp==0: done high in cycle 1, no reads, writes or sp_dec.
//  - Order: topmost entry -> dst_addr, next -> dst_addr+1, ...
//  - waddr wraps modulo 2**AW (0xFF+1 -> 0x00); no error.
//  - Underflow mid-burst: entries already moved stay written; remaining pops are dropped.
//    underflow rises with the FIN transition and holds until next accepted start.
//  - sp input read only at start; SP is owned externally and updated solely via sp_dec.
//  - Reset mid-operation: returns to IDLE next edge.
//    No dm_wen, sp_dec or done pulse is emitted for the aborted burst.
//  - Exactly one sp_dec per dm_wen; never more than one sp_dec per accepted start per entry.
// STRUCTURE
//  - stack_pkg: typedef enum logic [1:0] {IDLE,RD,WR,FIN} pop_state_t; default DW/AW/CW localparams
//    shared with the push path and stack RAM.
//  - Single flat module: FSM plus cnt/lsp/waddr registers; no sub-module warranted.
//  - Stack RAM and SP register live outside; bench provides a behavioural 1-cycle-read RAM model.
// TESTING
//  1. reset held 2 cycles, then released -> all outputs 0, busy=0; start during reset ignored.
//  2. sp=3, RAM[0..2]=11,22,33, pop_cnt=1, dst=0x40 -> RD addr 2, DM[0x40]=33, one sp_dec, done cycle 3.
//  3. sp=3, pop_cnt=3, dst=0xFE -> DM[0xFE]=33, DM[0xFF]=22, DM[0x00]=11 (wrap); 3 sp_dec; done cycle 7.
//  4. sp=2, pop_cnt=4 -> two writes (top two entries), underflow=1 with done in cycle 5;
//     underflow clears on next start.
//  5. sp=0 pop_cnt=2, and sp=5 pop_cnt=0 -> no stk_ren/dm_wen/sp_dec; done in cycle 1;
//     underflow=1 only in the sp=0 case.
//  6. reset asserted during 2nd WR of a 3-pop burst -> IDLE next edge, no done; second start
//     pulse while busy ignored.

Source files
------------

// File: rtl/stack_pkg.sv
// Types and default widths shared by the stack push/pop paths and the stack RAM.
// Pure declarations: no logic, no latency, no flow control.
package stack_pkg;

  localparam int STK_DW = 8;
  localparam int STK_AW = 8;
  localparam int STK_CW = 4;

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} pop_state_t;

endpackage

// File: rtl/stack_pop_unit.sv
// POP engine: moves pop_cnt entries from stack top to data memory; 2 cycles per entry, done one cycle after the last write.
// No backpressure: the RAM read is fixed one-cycle latency, and start is ignored while busy.
module stack_pop_unit
  import stack_pkg::*;
#(
  parameter int DW = STK_DW,
  parameter int AW = STK_AW,
  parameter int CW = STK_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] pop_cnt,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] sp,
  output logic          stk_ren,
  output logic [AW-1:0] stk_raddr,
  input  logic [DW-1:0] stk_rdata,
  output logic          sp_dec,
  output logic          dm_wen,
  output logic [AW-1:0] dm_waddr,
  output logic [DW-1:0] dm_wdata,
  output logic          busy,
  output logic          done,
  output logic          underflow
);

  pop_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] lsp_q, lsp_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          uf_q, uf_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lsp_q   <= '0;
      waddr_q <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lsp_q   <= lsp_d;
      waddr_q <= waddr_d;
      uf_q    <= uf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lsp_d     = lsp_q;
    waddr_d   = waddr_q;
    uf_d      = uf_q;
    stk_ren   = 1'b0;
    stk_raddr = '0;
    sp_dec    = 1'b0;
    dm_wen    = 1'b0;
    dm_waddr  = '0;
    dm_wdata  = '0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = pop_cnt;
          waddr_d = dst_addr;
          lsp_d   = sp;
          uf_d    = 1'b0;
          if (pop_cnt == '0) begin
            state_d = FIN;
          end else if (sp == '0) begin
            uf_d    = 1'b1;
            state_d = FIN;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        stk_ren   = 1'b1;
        stk_raddr = lsp_q - AW'(1);
        state_d   = WR;
      end
      WR: begin
        dm_wen   = 1'b1;
        dm_waddr = waddr_q;
        dm_wdata = stk_rdata;
        sp_dec   = 1'b1;
        lsp_d    = lsp_q - AW'(1);
        cnt_d    = cnt_q - CW'(1);
        waddr_d  = waddr_q + AW'(1);
        // Compare pre-decrement values against 1 to test the post-decrement zero.
        if (cnt_q == CW'(1)) begin
          state_d = FIN;
        end else if (lsp_q == AW'(1)) begin
          uf_d    = 1'b1;
          state_d = FIN;
        end else begin
          state_d = RD;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign underflow = uf_q;

endmodule

// File: tb/tb_stack_pop_unit.sv
// Directed bench for stack_pop_unit with a 1-cycle-read stack RAM model and a data memory model.
module tb_stack_pop_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] pop_cnt;
  logic [7:0] dst_addr;
  logic [7:0] sp;
  logic       stk_ren;
  logic [7:0] stk_raddr;
  logic [7:0] stk_rdata;
  logic       sp_dec;
  logic       dm_wen;
  logic [7:0] dm_waddr;
  logic [7:0] dm_wdata;
  logic       busy;
  logic       done;
  logic       underflow;

  logic [7:0] ram [0:255];
  logic [7:0] dm  [0:255];
  logic [7:0] raddr_q [$];

  int n_assert = 0;
  int n_fail   = 0;

  int   dcyc, n_ren, n_wr, n_dec, quiet;
  logic uf_done, uf_prev, busy1;

  always #5 clk = ~clk;

  stack_pop_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pop_cnt   (pop_cnt),
    .dst_addr  (dst_addr),
    .sp        (sp),
    .stk_ren   (stk_ren),
    .stk_raddr (stk_raddr),
    .stk_rdata (stk_rdata),
    .sp_dec    (sp_dec),
    .dm_wen    (dm_wen),
    .dm_waddr  (dm_waddr),
    .dm_wdata  (dm_wdata),
    .busy      (busy),
    .done      (done),
    .underflow (underflow)
  );

  always_ff @(posedge clk) begin
    if (stk_ren) stk_rdata <= ram[stk_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one start and watches the burst cycle by cycle (cycle k = k-th cycle after the start edge).
  task automatic run_op(input logic [3:0] c, input logic [7:0] d, input logic [7:0] s);
    raddr_q.delete();
    dcyc = 0; n_ren = 0; n_wr = 0; n_dec = 0;
    uf_done = 1'bx; uf_prev = 1'bx; busy1 = 1'bx;
    @(negedge clk);
    pop_cnt = c; dst_addr = d; sp = s; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) busy1 = busy;
      if (stk_ren) begin n_ren++; raddr_q.push_back(stk_raddr); end
      if (dm_wen) begin n_wr++; dm[dm_waddr] = dm_wdata; end
      if (sp_dec) n_dec++;
      if (dcyc != 0) begin
        chk("done_single_pulse", {31'd0, done}, 32'd0);
        break;
      end
      if (done) begin
        dcyc = k;
        uf_done = underflow;
      end else begin
        uf_prev = underflow;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = 8'h00; dm[i] = 8'h00; end
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44; ram[4] = 8'h55;

    // Test 1: reset with a start held high throughout
    reset = 1'b1; start = 1'b1; pop_cnt = 4'd1; dst_addr = 8'h00; sp = 8'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_stk_ren",   {31'd0, stk_ren},   32'd0);
    chk("rst_sp_dec",    {31'd0, sp_dec},    32'd0);
    chk("rst_dm_wen",    {31'd0, dm_wen},    32'd0);
    chk("rst_done",      {31'd0, done},      32'd0);
    chk("rst_underflow", {31'd0, underflow}, 32'd0);
    chk("rst_addrs",     {8'd0, stk_raddr, dm_waddr, dm_wdata}, 32'd0);
    @(negedge clk);
    chk("rst_start_ignored", {31'd0, busy}, 32'd0);

    // Test 2: single pop of the top entry
    run_op(4'd1, 8'h40, 8'd3);
    chk("t2_done_cycle", dcyc, 32'd3);
    chk("t2_busy",       {31'd0, busy1}, 32'd1);
    chk("t2_n_ren",      n_ren, 32'd1);
    chk("t2_raddr",      {24'd0, raddr_q[0]}, 32'h02);
    chk("t2_n_wr",       n_wr, 32'd1);
    chk("t2_dm40",       {24'd0, dm[8'h40]}, 32'h33);
    chk("t2_n_dec",      n_dec, 32'd1);
    chk("t2_underflow",  {31'd0, uf_done}, 32'd0);

    // Test 3: three pops wrapping the destination address
    run_op(4'd3, 8'hFE, 8'd3);
    chk("t3_done_cycle", dcyc, 32'd7);
    chk("t3_n_ren",      n_ren, 32'd3);
    chk("t3_raddr_last", {24'd0, raddr_q[2]}, 32'h00);
    chk("t3_n_wr",       n_wr, 32'd3);
    chk("t3_dmFE",       {24'd0, dm[8'hFE]}, 32'h33);
    chk("t3_dmFF",       {24'd0, dm[8'hFF]}, 32'h22);
    chk("t3_dm00",       {24'd0, dm[8'h00]}, 32'h11);
    chk("t3_n_dec",      n_dec, 32'd3);

    // Test 4: underflow mid-burst
    run_op(4'd4, 8'h80, 8'd2);
    chk("t4_done_cycle", dcyc, 32'd5);
    chk("t4_n_wr",       n_wr, 32'd2);
    chk("t4_dm80",       {24'd0, dm[8'h80]}, 32'h22);
    chk("t4_dm81",       {24'd0, dm[8'h81]}, 32'h11);
    chk("t4_dm82",       {24'd0, dm[8'h82]}, 32'h00);
    chk("t4_n_dec",      n_dec, 32'd2);
    chk("t4_uf_before",  {31'd0, uf_prev}, 32'd0);
    chk("t4_uf_done",    {31'd0, uf_done}, 32'd1);

    // Test 5b: zero count is a no-op and clears the previous underflow
    run_op(4'd0, 8'h10, 8'd5);
    chk("t5b_done_cycle", dcyc, 32'd1);
    chk("t5b_activity",   n_ren + n_wr + n_dec, 32'd0);
    chk("t5b_underflow",  {31'd0, uf_done}, 32'd0);

    // Test 5a: empty stack flags underflow without touching memory
    run_op(4'd2, 8'h20, 8'd0);
    chk("t5a_done_cycle", dcyc, 32'd1);
    chk("t5a_activity",   n_ren + n_wr + n_dec, 32'd0);
    chk("t5a_underflow",  {31'd0, uf_done}, 32'd1);
    repeat (3) @(negedge clk);
    chk("t5a_uf_sticky",  {31'd0, underflow}, 32'd1);
    chk("t5a_idle",       {31'd0, busy}, 32'd0);

    // Test 6: reset during the second write of a 3-pop burst, with a start pulse while busy
    @(negedge clk);
    pop_cnt = 4'd3; dst_addr = 8'h60; sp = 8'd3; start = 1'b1;
    @(negedge clk);                                  // cycle 1: RD
    chk("t6_uf_cleared", {31'd0, underflow}, 32'd0);
    chk("t6_busy",       {31'd0, busy}, 32'd1);
    pop_cnt = 4'd0; dst_addr = 8'h90; sp = 8'd0; start = 1'b1;
    @(negedge clk);                                  // cycle 2: WR
    start = 1'b0;
    chk("t6_wr1", {15'd0, dm_wen, dm_waddr, dm_wdata}, {15'd0, 1'b1, 8'h60, 8'h33});
    @(negedge clk);                                  // cycle 3: RD
    chk("t6_rd2", {23'd0, stk_ren, stk_raddr}, {23'd0, 1'b1, 8'h01});
    @(negedge clk);                                  // cycle 4: WR
    chk("t6_wr2", {15'd0, dm_wen, dm_waddr, dm_wdata}, {15'd0, 1'b1, 8'h61, 8'h22});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_idle_after_reset", {31'd0, busy}, 32'd0);
    quiet = 0;
    for (int k = 0; k < 6; k++) begin
      if (dm_wen || sp_dec || done || stk_ren) quiet++;
      @(negedge clk);
    end
    chk("t6_no_activity_after_reset", quiet, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
